// File: rtl/atan2_fix_if.sv
// atan2_fix_if: sample handshake and result bundle for the atan2_fix engine.
// The master side drives the (cos, sin) strobe; the slave side returns the angle.
interface atan2_fix_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
);
    logic                    i_ena;
    logic signed [IN_W-1:0]  i_cos;
    logic signed [IN_W-1:0]  i_sin;
    logic                    o_ready;
    logic signed [OUT_W-1:0] o_th;
    logic        [IN_W-1:0]  o_mag;
    logic                    o_valid;

    modport master (
        output i_ena, i_cos, i_sin,
        input  o_ready, o_th, o_mag, o_valid
    );

    modport slave (
        input  i_ena, i_cos, i_sin,
        output o_ready, o_th, o_mag, o_valid
    );
endinterface

// File: rtl/atan2_fix.sv
// atan2_fix: iterative CORDIC vectoring, (cos, sin) Q1.14 -> angle Q3.29 radians.
// Define ATAN2_FIX_MAG_EN to also produce the gain-corrected magnitude on o_mag.
module atan2_fix #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int ITER  = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    atan2_fix_if.slave bus
);
    localparam int XW = IN_W + 2;
    localparam int KW = 5;
    localparam logic signed [OUT_W-1:0] PI = OUT_W'(1686629713);
    localparam logic [IN_W-1:0] MAG_MAX = {1'b0, {(IN_W-1){1'b1}}};

    typedef enum logic [1:0] {IDLE, PRE, ROT, DONE} state_t;

    state_t                  state_q, state_d;
    logic [KW-1:0]           k_q, k_d;
    logic signed [XW-1:0]    x_q, x_d, y_q, y_d;
    logic signed [XW-1:0]    x_sh, y_sh;
    logic signed [OUT_W-1:0] z_q, z_d, th_q, th_d, atan_k;
    logic                    zero_q, zero_d, valid_q, valid_d;
    logic [IN_W-1:0]         mag_q, mag_d, mag_calc;

    function automatic logic signed [31:0] atan_lut(input logic [KW-1:0] k);
        case (k)
            5'd0:    atan_lut = 32'sd421657428;
            5'd1:    atan_lut = 32'sd248918914;
            5'd2:    atan_lut = 32'sd131521918;
            5'd3:    atan_lut = 32'sd66762579;
            5'd4:    atan_lut = 32'sd33510843;
            5'd5:    atan_lut = 32'sd16771758;
            5'd6:    atan_lut = 32'sd8387925;
            5'd7:    atan_lut = 32'sd4194219;
            5'd8:    atan_lut = 32'sd2097141;
            5'd9:    atan_lut = 32'sd1048575;
            5'd10:   atan_lut = 32'sd524288;
            5'd11:   atan_lut = 32'sd262144;
            5'd12:   atan_lut = 32'sd131072;
            5'd13:   atan_lut = 32'sd65536;
            5'd14:   atan_lut = 32'sd32768;
            5'd15:   atan_lut = 32'sd16384;
            5'd16:   atan_lut = 32'sd8192;
            5'd17:   atan_lut = 32'sd4096;
            5'd18:   atan_lut = 32'sd2048;
            5'd19:   atan_lut = 32'sd1024;
            5'd20:   atan_lut = 32'sd512;
            5'd21:   atan_lut = 32'sd256;
            5'd22:   atan_lut = 32'sd128;
            5'd23:   atan_lut = 32'sd64;
            default: atan_lut = 32'sd0;
        endcase
    endfunction

`ifdef ATAN2_FIX_MAG_EN
    localparam int PW = XW + 16;
    logic [PW-1:0] prod;
    logic [XW-1:0] mag_full;

    // x is non-negative after the fold, so an unsigned multiply by K is safe.
    always_comb begin
        prod     = PW'($unsigned(x_q)) * PW'(39797) + PW'(32768);
        mag_full = XW'(prod >> 16);
        mag_calc = (mag_full > XW'(MAG_MAX)) ? MAG_MAX
                                             : mag_full[IN_W-1:0];
    end
`else
    assign mag_calc = '0;
`endif

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        zero_d  = zero_q;
        th_d    = th_q;
        mag_d   = mag_q;
        valid_d = 1'b0;
        x_sh    = x_q >>> k_q;
        y_sh    = y_q >>> k_q;
        atan_k  = OUT_W'(atan_lut(k_q));
        unique case (state_q)
            IDLE: begin
                if (bus.i_ena) begin
                    x_d     = {{2{bus.i_cos[IN_W-1]}}, bus.i_cos};
                    y_d     = {{2{bus.i_sin[IN_W-1]}}, bus.i_sin};
                    z_d     = '0;
                    k_d     = '0;
                    zero_d  = (bus.i_cos == '0) && (bus.i_sin == '0);
                    state_d = PRE;
                end
            end
            PRE: begin
                // Left half-plane: rotate by pi so ROT only sees x >= 0.
                if (x_q[XW-1]) begin
                    x_d = -x_q;
                    y_d = -y_q;
                    z_d = y_q[XW-1] ? -PI : PI;
                end
                state_d = ROT;
            end
            ROT: begin
                if (!y_q[XW-1]) begin
                    x_d = x_q + y_sh;
                    y_d = y_q - x_sh;
                    z_d = z_q + atan_k;
                end else begin
                    x_d = x_q - y_sh;
                    y_d = y_q + x_sh;
                    z_d = z_q - atan_k;
                end
                if (k_q == KW'(ITER - 1)) begin
                    k_d     = '0;
                    state_d = DONE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            DONE: begin
                // A zero vector has no angle; report 0 rather than sum(ATAN).
                th_d    = zero_q ? '0 : z_q;
                mag_d   = mag_calc;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            zero_q  <= 1'b0;
            th_q    <= '0;
            mag_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            zero_q  <= zero_d;
            th_q    <= th_d;
            mag_q   <= mag_d;
            valid_q <= valid_d;
        end
    end

    assign bus.o_ready = (state_q == IDLE);
    assign bus.o_valid = valid_q;
    assign bus.o_th    = th_q;
    assign bus.o_mag   = mag_q;
endmodule
